n64a_vinfo_ext: RTL and testbench

Video-info extractor and sequencer for the N64 digital video input demultiplexer. It runs on the raw VCLK/nVDSYNC/VD stream and generates the packed demux parameter word: sub-pixel phase counter, PAL/NTSC mode, deblur enable and 15-bit mode. It also derives frame-level information (interlace flag, field parity, lines per field) from the sync nibble. It sits directly upstream of the demux stage, sharing its clock and its view of VD.

---
 rtl/n64a_vinfo_ext_pkg.sv | 26 ++
 rtl/n64a_vinfo_ext_linecnt.sv | 52 +++++
 rtl/n64a_vinfo_ext.sv | 125 ++++++++++++
 tb/tb_n64a_vinfo_ext.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/n64a_vinfo_ext_pkg.sv
// Shared video-parameter definitions for the N64 video-info extractor and the demux stage.
// Field positions of the packed demux parameter word and sync nibble bit indices.
package n64a_vinfo_ext_pkg;

    localparam int unsigned DC_HI       = 4;
    localparam int unsigned DC_LO       = 3;
    localparam int unsigned VMODE_BIT   = 2;
    localparam int unsigned NDEBLUR_BIT = 1;
    localparam int unsigned N15BIT_BIT  = 0;

    localparam int unsigned SYNC_NVSYNC = 3;
    localparam int unsigned SYNC_NCLAMP = 2;
    localparam int unsigned SYNC_NHSYNC = 1;
    localparam int unsigned SYNC_NCSYNC = 0;

    localparam int unsigned PAL_LINE_TH_DEF = 288;

    // Packed order matches the bit positions above.
    typedef struct packed {
        logic [1:0] data_cnt;
        logic       vmode;
        logic       ndo_deblur;
        logic       n15bit_mode;
    } demuxparams_t;

endpackage

// File: rtl/n64a_vinfo_ext_linecnt.sv
// Saturating line counter with field-end capture, PAL classification and line-count LSB difference.
// pal_o / lsb_diff_o describe the field that ends on the current cycle (valid when vs_fall_i is high).
module n64a_linecnt
    import n64a_vinfo_ext_pkg::*;
#(
    parameter int unsigned LCNT_W      = 10,
    parameter int unsigned PAL_LINE_TH = PAL_LINE_TH_DEF
) (
    input  logic              VCLK,
    input  logic              RST,
    input  logic              hs_fall_i,
    input  logic              vs_fall_i,
    output logic              pal_o,
    output logic              lsb_diff_o,
    output logic [LCNT_W-1:0] lines_o
);

    logic [LCNT_W-1:0] cnt_q, cnt_d;
    logic [LCNT_W-1:0] lines_q, lines_d;
    logic              lsb_q, lsb_d;

    always_comb begin
        cnt_d   = cnt_q;
        lines_d = lines_q;
        lsb_d   = lsb_q;
        if (vs_fall_i) begin
            lines_d = cnt_q;
            lsb_d   = cnt_q[0];
            // A coincident nHSYNC fall is the first line of the new field.
            cnt_d   = hs_fall_i ? LCNT_W'(1) : '0;
        end else if (hs_fall_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + LCNT_W'(1);
        end
    end

    always_ff @(posedge VCLK) begin
        if (RST) begin
            cnt_q   <= '0;
            lines_q <= '0;
            lsb_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            lines_q <= lines_d;
            lsb_q   <= lsb_d;
        end
    end

    assign pal_o      = (32'(cnt_q) >= PAL_LINE_TH);
    assign lsb_diff_o = cnt_q[0] ^ lsb_q;
    assign lines_o    = lines_q;

endmodule

// File: rtl/n64a_vinfo_ext.sv
// Video-info extractor: sub-pixel phase counter, debounced PAL/480i detection, field parity
// and deblur gating, packed into the demux parameter word.
module n64a_vinfo_ext
    import n64a_vinfo_ext_pkg::*;
#(
    parameter int unsigned PAL_LINE_TH = PAL_LINE_TH_DEF,
    parameter int unsigned LCNT_W      = 10
) (
    input  logic              VCLK,
    input  logic              RST,
    input  logic              nVDSYNC,
    input  logic [6:0]        VD_i,
    input  logic              deblur_en_i,
    input  logic              n15bit_mode_i,
    output logic [4:0]        demuxparams_o,
    output logic              n64_480i_o,
    output logic              field_o,
    output logic [LCNT_W-1:0] lines_o
);

    logic       sync_cyc, hs_fall, vs_fall, pal, lsb_diff;
    logic       vd_unused;
    logic [3:0] sync_prev_q, sync_prev_d;
    logic [1:0] data_cnt_q, data_cnt_d;
    logic       vmode_q, vmode_d;
    logic       ndb_q, ndb_d;
    logic       n15_q, n15_d;
    logic       n480_q, n480_d;
    logic       field_q, field_d;
    logic       first_fld_q, first_fld_d;
    logic       hist_vld_q, hist_vld_d;
    logic       pal_prev_q, pal_prev_d;
    logic       diff_prev_q, diff_prev_d;
    demuxparams_t dp;

    assign vd_unused = ^VD_i[6:4];
    assign sync_cyc  = ~nVDSYNC;
    // Edges are only ever taken between two sync cycles; colour cycles never touch sync_prev.
    assign hs_fall   = sync_cyc & sync_prev_q[SYNC_NHSYNC] & ~VD_i[SYNC_NHSYNC];
    assign vs_fall   = sync_cyc & sync_prev_q[SYNC_NVSYNC] & ~VD_i[SYNC_NVSYNC];

    n64a_linecnt #(
        .LCNT_W      (LCNT_W),
        .PAL_LINE_TH (PAL_LINE_TH)
    ) u_linecnt (
        .VCLK       (VCLK),
        .RST        (RST),
        .hs_fall_i  (hs_fall),
        .vs_fall_i  (vs_fall),
        .pal_o      (pal),
        .lsb_diff_o (lsb_diff),
        .lines_o    (lines_o)
    );

    always_comb begin
        sync_prev_d = sync_cyc ? VD_i[3:0] : sync_prev_q;
        data_cnt_d  = sync_cyc ? 2'b01 : data_cnt_q + 2'd1;
        n15_d       = n15bit_mode_i;
        vmode_d     = vmode_q;
        ndb_d       = ndb_q;
        n480_d      = n480_q;
        field_d     = field_q;
        first_fld_d = first_fld_q;
        hist_vld_d  = hist_vld_q;
        pal_prev_d  = pal_prev_q;
        diff_prev_d = diff_prev_q;
        if (vs_fall) begin
            first_fld_d = 1'b0;
            // The first field after reset is partial: nothing it measured is trusted.
            if (!first_fld_q) begin
                if (hist_vld_q && lsb_diff && diff_prev_q)
                    n480_d = 1'b1;
                else if (hist_vld_q && !lsb_diff && !diff_prev_q)
                    n480_d = 1'b0;
                if (hist_vld_q && (pal == pal_prev_q) && (pal != vmode_q))
                    vmode_d = pal;
                pal_prev_d  = pal;
                diff_prev_d = lsb_diff;
                hist_vld_d  = 1'b1;
                field_d     = n480_d ? ~field_q : 1'b0;
                ndb_d       = ~(deblur_en_i & ~n480_d);
            end
        end
    end

    always_ff @(posedge VCLK) begin
        if (RST) begin
            sync_prev_q <= 4'hF;
            data_cnt_q  <= 2'b00;
            vmode_q     <= 1'b0;
            ndb_q       <= 1'b1;
            n15_q       <= 1'b0;
            n480_q      <= 1'b0;
            field_q     <= 1'b0;
            first_fld_q <= 1'b1;
            hist_vld_q  <= 1'b0;
            pal_prev_q  <= 1'b0;
            diff_prev_q <= 1'b0;
        end else begin
            sync_prev_q <= sync_prev_d;
            data_cnt_q  <= data_cnt_d;
            vmode_q     <= vmode_d;
            ndb_q       <= ndb_d;
            n15_q       <= n15_d;
            n480_q      <= n480_d;
            field_q     <= field_d;
            first_fld_q <= first_fld_d;
            hist_vld_q  <= hist_vld_d;
            pal_prev_q  <= pal_prev_d;
            diff_prev_q <= diff_prev_d;
        end
    end

    always_comb begin
        dp.data_cnt    = data_cnt_q;
        dp.vmode       = vmode_q;
        dp.ndo_deblur  = ndb_q;
        dp.n15bit_mode = n15_q;
    end

    assign demuxparams_o = dp;
    assign n64_480i_o    = n480_q;
    assign field_o       = field_q;

endmodule

// File: tb/tb_n64a_vinfo_ext.sv
module tb_n64a_vinfo_ext;

  logic       VCLK = 1'b0;
  logic       RST = 1'b1;
  logic       nVDSYNC = 1'b1;
  logic [6:0] VD_i = 7'h00;
  logic       deblur_en_i = 1'b1;
  logic       n15bit_mode_i = 1'b1;
  logic [4:0] demuxparams_o;
  logic       n64_480i_o;
  logic       field_o;
  logic [9:0] lines_o;

  n64a_vinfo_ext #(
    .PAL_LINE_TH (288),
    .LCNT_W      (10)
  ) dut (
    .VCLK          (VCLK),
    .RST           (RST),
    .nVDSYNC       (nVDSYNC),
    .VD_i          (VD_i),
    .deblur_en_i   (deblur_en_i),
    .n15bit_mode_i (n15bit_mode_i),
    .demuxparams_o (demuxparams_o),
    .n64_480i_o    (n64_480i_o),
    .field_o       (field_o),
    .lines_o       (lines_o)
  );

  always #5 VCLK = ~VCLK;

  int unsigned cyc = 0;
  always @(posedge VCLK) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [16:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [16:0] st(input logic [1:0] dc, input logic vm, input logic ndb,
                                     input logic n15, input logic i480, input logic fld,
                                     input logic [9:0] ln);
    return {dc, vm, ndb, n15, i480, fld, ln};
  endfunction

  task automatic expect_next(input string name, input logic [16:0] v);
    exp_t e;
    e.cyc  = cyc + 1;
    e.name = name;
    e.exp  = v;
    sb.push_back(e);
  endtask

  always @(negedge VCLK) begin
    exp_t        e;
    logic [16:0] act;
    act = {demuxparams_o, n64_480i_o, field_o, lines_o};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || act !== e.exp) begin
        errors++;
        $display("FAIL %s cyc=%0d actual=%h required=%h (demux/480i/field/lines packed)",
                 e.name, cyc, act, e.exp);
      end
    end
  end

  task automatic sync_cyc(input logic [3:0] nib);
    @(negedge VCLK);
    nVDSYNC = 1'b0;
    VD_i    = {3'b101, nib};
  endtask

  task automatic colour_cyc();
    @(negedge VCLK);
    nVDSYNC = 1'b1;
    VD_i    = 7'h00;
  endtask

  task automatic pix(input logic [3:0] nib);
    sync_cyc(nib);
    repeat (3) colour_cyc();
  endtask

  task automatic lines(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      pix(4'b1100);
      pix(4'b1111);
    end
  endtask

  task automatic fend(input bit simul, input string name, input logic vm, input logic ndb,
                      input logic i480, input logic fld, input logic [9:0] ln);
    sync_cyc(simul ? 4'b0100 : 4'b0111);
    expect_next(name, st(2'b01, vm, ndb, 1'b1, i480, fld, ln));
    repeat (3) colour_cyc();
    pix(4'b1111);
  endtask

  initial begin
    repeat (3) @(negedge VCLK);
    expect_next("reset", st(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0));
    @(negedge VCLK);
    RST = 1'b0;

    sync_cyc(4'hF);
    expect_next("ph_sync", st(2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0));
    for (int unsigned i = 0; i < 8; i++) begin
      colour_cyc();
      n15bit_mode_i = (i != 4);
      expect_next("ph_free", st(2'(i + 2), 1'b0, 1'b1, (i != 4), 1'b0, 1'b0, 10'd0));
    end
    colour_cyc();
    n15bit_mode_i = 1'b1;

    lines(20);  fend(0, "f1_first", 0, 1, 0, 0, 10'd20);
    lines(263); fend(0, "ntsc_f2",  0, 0, 0, 0, 10'd263);
    lines(263); fend(0, "ntsc_f3",  0, 0, 0, 0, 10'd263);
    lines(263); fend(0, "ntsc_f4",  0, 0, 0, 0, 10'd263);
    lines(313); fend(0, "pal_f1",   0, 0, 0, 0, 10'd313);
    lines(313); fend(0, "pal_f2",   1, 0, 0, 0, 10'd313);
    lines(262); fend(0, "il_262a",  1, 0, 0, 0, 10'd262);
    lines(263); fend(0, "il_263a",  0, 1, 1, 1, 10'd263);
    lines(262); fend(0, "il_262b",  0, 1, 1, 0, 10'd262);
    lines(263); fend(0, "il_263b",  0, 1, 1, 1, 10'd263);
    lines(313); fend(0, "il_exit1", 0, 1, 1, 0, 10'd313);
    lines(313); fend(0, "il_exit2", 1, 0, 0, 0, 10'd313);

    lines(100);
    @(negedge VCLK);
    RST     = 1'b1;
    nVDSYNC = 1'b1;
    VD_i    = 7'h00;
    expect_next("rst_mid", st(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0));
    @(negedge VCLK);
    RST = 1'b0;
    lines(213); fend(0, "rst_f1",   0, 1, 0, 0, 10'd213);
    lines(313); fend(0, "rst_f2",   0, 0, 0, 0, 10'd313);
    lines(313); fend(0, "rst_f3",   1, 0, 0, 0, 10'd313);

    lines(313); fend(1, "simul_fe",   1, 0, 0, 0, 10'd313);
    lines(49);  fend(0, "simul_next", 1, 0, 0, 0, 10'd50);
    lines(1100); fend(0, "sat",       1, 1, 1, 1, 10'd1023);

    repeat (5) @(negedge VCLK);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s never compared: actual=none required=%h", e.name, e.exp);
    end

    checks++;
    if (lines_o !== 10'd1023) begin
      errors++;
      $display("FAIL final_lines actual=%0d required=1023", lines_o);
    end
    checks++;
    if (n64_480i_o !== 1'b1) begin
      errors++;
      $display("FAIL final_480i actual=%b required=1", n64_480i_o);
    end
    checks++;
    if (field_o !== 1'b1) begin
      errors++;
      $display("FAIL final_field actual=%b required=1", field_o);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
